issue_scoreboard: RTL and testbench



---
 rtl/issue_scoreboard.sv | 191 +++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue, out-of-order writeback, in-order commit
// scoreboard with a two-source busy/forwarding lookup.
// Optional feature macro: SB_FORWARD_EN (result forwarding on the rs_* lookup).
// Without it, rs_fwd_valid_o and rs_fwd_data_o are tied to zero.
module issue_scoreboard #(
  parameter  int unsigned NR_ENTRIES  = 4,
  parameter  int unsigned NR_WB_PORTS = 4,
  parameter  int unsigned DATA_WIDTH  = 64,
  localparam int unsigned ID_W        = $clog2(NR_ENTRIES)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  // issue side
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic [4:0]                        issue_rd_i,
  output logic [ID_W-1:0]                   issue_trans_id_o,
  // writeback ports
  input  logic [NR_WB_PORTS-1:0]            wb_valid_i,
  input  logic [NR_WB_PORTS*ID_W-1:0]       wb_trans_id_i,
  input  logic [NR_WB_PORTS*DATA_WIDTH-1:0] wb_result_i,
  input  logic [NR_WB_PORTS-1:0]            wb_ex_i,
  // commit side
  output logic                              commit_valid_o,
  input  logic                              commit_ack_i,
  output logic [ID_W-1:0]                   commit_trans_id_o,
  output logic [4:0]                        commit_rd_o,
  output logic [DATA_WIDTH-1:0]             commit_result_o,
  output logic                              commit_ex_o,
  // source operand lookup
  input  logic [2*5-1:0]                    rs_addr_i,
  output logic [1:0]                        rs_busy_o,
  output logic [1:0]                        rs_fwd_valid_o,
  output logic [2*DATA_WIDTH-1:0]           rs_fwd_data_o
);

  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(NR_ENTRIES);

  // per-entry state
  logic [NR_ENTRIES-1:0] alloc_q, alloc_d;
  logic [NR_ENTRIES-1:0] done_q, done_d;
  logic [NR_ENTRIES-1:0] ex_q, ex_d;
  logic [4:0]            rd_q     [NR_ENTRIES];
  logic [4:0]            rd_d     [NR_ENTRIES];
  logic [DATA_WIDTH-1:0] result_q [NR_ENTRIES];
  logic [DATA_WIDTH-1:0] result_d [NR_ENTRIES];

  // queue pointers and occupancy
  logic [ID_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ID_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ID_W:0]   cnt_q, cnt_d;

  logic issue_fire;
  logic commit_fire;

  // issue/commit handshakes; both depend only on registered state and flush_i
  assign issue_ready_o     = (cnt_q != FULL_CNT) && !flush_i;
  assign issue_trans_id_o  = wr_ptr_q;
  assign commit_valid_o    = alloc_q[rd_ptr_q] && done_q[rd_ptr_q] && !flush_i;
  assign commit_trans_id_o = rd_ptr_q;
  assign commit_rd_o       = rd_q[rd_ptr_q];
  assign commit_result_o   = result_q[rd_ptr_q];
  assign commit_ex_o       = ex_q[rd_ptr_q];

  assign issue_fire  = issue_valid_i && issue_ready_o;
  assign commit_fire = commit_valid_o && commit_ack_i;

  // next-state: writeback first, then commit frees the head, then issue allocates the tail
  always_comb begin
    logic [NR_ENTRIES-1:0] wb_taken;
    logic [ID_W-1:0]       wb_id;
    // NOTE: every always_comb target gets a default up front so no path leaves it unassigned (no latch).
    alloc_d  = alloc_q;
    done_d   = done_q;
    ex_d     = ex_q;
    rd_d     = rd_q;
    result_d = result_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    wb_taken = '0;
    wb_id    = '0;

    if (flush_i) begin
      alloc_d  = '0;
      done_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // ascending port order: a lower port claims an ID before any higher one can
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
        if (wb_valid_i[k]) begin
          wb_id = wb_trans_id_i[k*ID_W +: ID_W];
          if (alloc_q[wb_id] && !wb_taken[wb_id]) begin
            done_d[wb_id]   = 1'b1;
            ex_d[wb_id]     = wb_ex_i[k];
            result_d[wb_id] = wb_result_i[k*DATA_WIDTH +: DATA_WIDTH];
          end
          wb_taken[wb_id] = 1'b1;
        end
      end

      if (commit_fire) begin
        alloc_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + ID_W'(1);
      end

      // the tail slot is free whenever issue_ready_o is high, so it never collides with the head
      if (issue_fire) begin
        alloc_d[wr_ptr_q] = 1'b1;
        done_d[wr_ptr_q]  = 1'b0;
        ex_d[wr_ptr_q]    = 1'b0;
        rd_d[wr_ptr_q]    = issue_rd_i;
        wr_ptr_d          = wr_ptr_q + ID_W'(1);
      end

      cnt_d = cnt_q + (ID_W+1)'(issue_fire) - (ID_W+1)'(commit_fire);
    end
  end

  // state register with asynchronous clear of every entry field
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q  <= '0;
      done_q   <= '0;
      ex_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      // NOTE: the entry array is small and its contents drive commit_* directly, so it is reset too.
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        rd_q[i]     <= '0;
        result_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment only.
      alloc_q  <= alloc_d;
      done_q   <= done_d;
      ex_q     <= ex_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  // source lookup: scan oldest to youngest so the youngest matching producer is kept
  always_comb begin
    logic [4:0]      addr;
    logic [ID_W-1:0] idx;
    logic            hit;
`ifdef SB_FORWARD_EN
    logic                  hit_done;
    logic [DATA_WIDTH-1:0] hit_data;
`endif
    rs_busy_o      = '0;
    rs_fwd_valid_o = '0;
    rs_fwd_data_o  = '0;
    addr           = '0;
    idx            = '0;
    hit            = 1'b0;
    for (int s = 0; s < 2; s++) begin
      addr = rs_addr_i[s*5 +: 5];
      hit  = 1'b0;
`ifdef SB_FORWARD_EN
      hit_done = 1'b0;
      hit_data = '0;
`endif
      for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
        idx = wr_ptr_q - ID_W'(i) - ID_W'(1);
        if (alloc_q[idx] && (rd_q[idx] == addr)) begin
          hit = 1'b1;
`ifdef SB_FORWARD_EN
          hit_done = done_q[idx];
          hit_data = result_q[idx];
`endif
        end
      end
      rs_busy_o[s] = hit && (addr != 5'd0);
`ifdef SB_FORWARD_EN
      rs_fwd_valid_o[s] = rs_busy_o[s] && hit_done;
      rs_fwd_data_o[s*DATA_WIDTH +: DATA_WIDTH] =
        (rs_busy_o[s] && hit_done) ? hit_data : '0;
`endif
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomised and directed stimulus for issue_scoreboard, checked against a
// program-order queue model of in-flight instructions.
module tb_issue_scoreboard;

  localparam int N    = 4;
  localparam int P    = 4;
  localparam int W    = 64;
  localparam int ID_W = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [4:0]        issue_rd_i;
  logic [ID_W-1:0]   issue_trans_id_o;
  logic [P-1:0]      wb_valid_i;
  logic [P*ID_W-1:0] wb_trans_id_i;
  logic [P*W-1:0]    wb_result_i;
  logic [P-1:0]      wb_ex_i;
  logic              commit_valid_o;
  logic              commit_ack_i;
  logic [ID_W-1:0]   commit_trans_id_o;
  logic [4:0]        commit_rd_o;
  logic [W-1:0]      commit_result_o;
  logic              commit_ex_o;
  logic [9:0]        rs_addr_i;
  logic [1:0]        rs_busy_o;
  logic [1:0]        rs_fwd_valid_o;
  logic [2*W-1:0]    rs_fwd_data_o;

  issue_scoreboard #(.NR_ENTRIES(N), .NR_WB_PORTS(P), .DATA_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rd_i(issue_rd_i), .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
    .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
    .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
    .commit_trans_id_o(commit_trans_id_o), .commit_rd_o(commit_rd_o),
    .commit_result_o(commit_result_o), .commit_ex_o(commit_ex_o),
    .rs_addr_i(rs_addr_i), .rs_busy_o(rs_busy_o),
    .rs_fwd_valid_o(rs_fwd_valid_o), .rs_fwd_data_o(rs_fwd_data_o)
  );

  always #5 clk_i = ~clk_i;

  // in-flight instruction, in program order
  typedef struct {
    int         id;
    logic [4:0] rd;
    bit         done;
    logic [W-1:0] res;
    bit         ex;
  } ent_t;

  ent_t q[$];
  int   next_id = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    wb_valid_i    = '0;
    wb_trans_id_i = '0;
    wb_result_i   = '0;
    wb_ex_i       = '0;
    commit_ack_i  = 1'b0;
    rs_addr_i     = '0;
  endtask

  task automatic set_wb(input int k, input int id, input logic [W-1:0] res, input bit ex);
    wb_valid_i[k]               = 1'b1;
    wb_trans_id_i[k*ID_W +: ID_W] = ID_W'(id);
    wb_result_i[k*W +: W]       = res;
    wb_ex_i[k]                  = ex;
  endtask

  // check outputs against the model for the current inputs, then advance one clock
  task automatic tick();
    bit           exp_ready, exp_cv, seen[N];
    logic [4:0]   addr;
    bit           eb, ev;
    logic [W-1:0] ed;
    int           id;
    #1;
    exp_ready = (q.size() != N) && !flush_i;
    exp_cv    = (q.size() > 0) && q[0].done && !flush_i;
    check("issue_ready", issue_ready_o, exp_ready);
    check("issue_id", issue_trans_id_o, next_id);
    check("commit_valid", commit_valid_o, exp_cv);
    check("commit_id", commit_trans_id_o, (q.size() > 0) ? q[0].id : next_id);
    if (exp_cv) begin
      check("commit_rd", commit_rd_o, q[0].rd);
      check("commit_result", commit_result_o, q[0].res);
      check("commit_ex", commit_ex_o, q[0].ex);
    end
    for (int s = 0; s < 2; s++) begin
      addr = rs_addr_i[s*5 +: 5];
      eb = 0; ev = 0; ed = '0;
      if (addr != 0) begin
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (q[j].rd == addr) begin
            eb = 1; ev = q[j].done; ed = q[j].res;
            break;
          end
        end
      end
`ifdef SB_FORWARD_EN
      if (!ev) ed = '0;
`else
      ev = 0; ed = '0;
`endif
      check($sformatf("rs_busy%0d", s), rs_busy_o[s], eb);
      check($sformatf("rs_fwd_valid%0d", s), rs_fwd_valid_o[s], ev);
      check($sformatf("rs_fwd_data%0d", s), rs_fwd_data_o[s*W +: W], ed);
    end

    @(posedge clk_i);
    if (flush_i) begin
      q.delete();
      next_id = 0;
    end else begin
      foreach (seen[i]) seen[i] = 0;
      for (int k = 0; k < P; k++) begin
        if (wb_valid_i[k]) begin
          id = int'(wb_trans_id_i[k*ID_W +: ID_W]);
          if (!seen[id]) begin
            seen[id] = 1;
            foreach (q[j]) if (q[j].id == id) begin
              q[j].done = 1; q[j].res = wb_result_i[k*W +: W]; q[j].ex = wb_ex_i[k];
            end
          end
        end
      end
      if (exp_cv && commit_ack_i) void'(q.pop_front());
      if (exp_ready && issue_valid_i) begin
        q.push_back('{id: next_id, rd: issue_rd_i, done: 0, res: '0, ex: 0});
        next_id = (next_id + 1) % N;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic rand_inputs();
    idle();
    flush_i       = ($urandom_range(0, 99) < 3);
    issue_valid_i = ($urandom_range(0, 99) < 60);
    issue_rd_i    = 5'($urandom_range(0, 7));
    commit_ack_i  = ($urandom_range(0, 99) < 70);
    rs_addr_i     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    for (int k = 0; k < P; k++)
      if ($urandom_range(0, 99) < 35)
        set_wb(k, $urandom_range(0, N-1), {$urandom, $urandom}, $urandom_range(0, 1) == 1);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_ready"}, issue_ready_o, 1'b1);
    check({tag, "_issue_id"}, issue_trans_id_o, 0);
    check({tag, "_commit_valid"}, commit_valid_o, 1'b0);
    check({tag, "_commit_id"}, commit_trans_id_o, 0);
    check({tag, "_commit_rd"}, commit_rd_o, 0);
    check({tag, "_commit_result"}, commit_result_o, 0);
    check({tag, "_commit_ex"}, commit_ex_o, 1'b0);
    check({tag, "_busy"}, rs_busy_o, 2'b00);
    check({tag, "_fwd_valid"}, rs_fwd_valid_o, 2'b00);
    check({tag, "_fwd_data"}, rs_fwd_data_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    rs_addr_i = {5'd1, 5'd2};
    #22;
    reset_values("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();

    // fill with rd=1..4, then try one more while full
    for (int r = 1; r <= 4; r++) begin
      idle(); issue_valid_i = 1; issue_rd_i = 5'(r); tick();
    end
    idle(); issue_valid_i = 1; issue_rd_i = 5'd9; tick();

    // out-of-order writeback 2,0,3,1 with commit_ack held high
    begin
      int ids[4] = '{2, 0, 3, 1};
      logic [W-1:0] res[4] = '{64'h20, 64'h00, 64'h30, 64'h10};
      for (int i = 0; i < 4; i++) begin
        idle(); commit_ack_i = 1; set_wb(0, ids[i], res[i], 0); tick();
      end
      for (int i = 0; i < 4; i++) begin
        idle(); commit_ack_i = 1; tick();
      end
    end

    // two ports hit the same ID in one cycle: lower port wins
    idle(); flush_i = 1; tick();
    for (int i = 0; i < 2; i++) begin
      idle(); issue_valid_i = 1; issue_rd_i = 5'd7; tick();
    end
    idle(); set_wb(0, 1, 64'hAA, 0); set_wb(2, 1, 64'hBB, 1); set_wb(1, 0, 64'h01, 0); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); commit_ack_i = 1; tick();
    end

    // youngest-producer lookup and forwarding
    idle(); flush_i = 1; tick();
    for (int i = 0; i < 2; i++) begin
      idle(); issue_valid_i = 1; issue_rd_i = 5'd5; rs_addr_i = {5'd5, 5'd5}; tick();
    end
    idle(); set_wb(0, 0, 64'h44, 0); rs_addr_i = {5'd0, 5'd5}; tick();
    idle(); rs_addr_i = {5'd0, 5'd5}; tick();
    idle(); set_wb(3, 1, 64'h55, 0); rs_addr_i = {5'd5, 5'd5}; tick();
    idle(); rs_addr_i = {5'd5, 5'd1}; tick();

    // flush with concurrent issue and writeback, then a stale writeback to ID0
    idle(); flush_i = 1; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); issue_valid_i = 1; issue_rd_i = 5'(i + 2); tick();
    end
    idle(); flush_i = 1; issue_valid_i = 1; issue_rd_i = 5'd3; set_wb(0, 0, 64'h77, 0);
    commit_ack_i = 1; tick();
    idle(); set_wb(0, 0, 64'h78, 0); rs_addr_i = {5'd2, 5'd3}; tick();
    idle(); tick();

    // full, then commit+issue same cycle; wr_ptr wraps to the freed slot next cycle
    idle(); flush_i = 1; tick();
    for (int i = 0; i < 4; i++) begin
      idle(); issue_valid_i = 1; issue_rd_i = 5'(i + 10); tick();
    end
    idle(); set_wb(1, 0, 64'hC0, 1); tick();
    idle(); issue_valid_i = 1; issue_rd_i = 5'd20; commit_ack_i = 1; tick();
    idle(); issue_valid_i = 1; issue_rd_i = 5'd20; tick();
    idle(); rs_addr_i = {5'd20, 5'd10}; tick();

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rand_inputs(); tick();
    end

    // asynchronous reset in the middle of a cycle
    for (int c = 0; c < 20; c++) begin
      rand_inputs(); flush_i = 0; tick();
    end
    idle(); rs_addr_i = {5'd3, 5'd4};
    #2 rst_ni = 1'b0;
    #1 reset_values("async_rst");
    q.delete(); next_id = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 300; c++) begin
      rand_inputs(); tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
